// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//
// Definitions shared by the fetch-side pipeline blocks:
//   FETCH_XLEN    - PC/address width of the fetch datapath
//   NOP_INSTR     - encoding of ADDI x0,x0,0, driven to fetch when idle
//   fetch_entry_t - one prefetched instruction tagged with its PC
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int FETCH_XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage : pipeline_pkg

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
//
// In-order circular buffer of fetch_entry_t used by instr_prefetch_queue.
// Pointers are $clog2(DEPTH) bits and wrap naturally, so DEPTH must be a
// power of two. The owner guarantees it never pushes into a full buffer
// without a simultaneous pop and never pops an empty one.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   drop all entries and reset both pointers (wins over push/pop)
//   push       in   write push_entry at the tail
//   push_entry in   entry to write
//   pop        in   remove the head entry
//   count      out  current occupancy, 0..DEPTH
//   head       out  entry at the head; meaningless while count == 0
// -----------------------------------------------------------------------------
module instr_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  fetch_entry_t  slots [DEPTH];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_ONE;
      if (pop)  head_ptr <= head_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;  // idle, or push and pop cancel out
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, because occupancy is tracked by the reset counter above.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[tail_ptr] <= push_entry;
  end

  assign head = slots[head_ptr];

endmodule : instr_fifo

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Prefetch buffer between the instruction memory port and fetch. Issues
// sequential word-aligned requests ahead of consumption, queues the returned
// instructions with their PCs and hands them to fetch over a valid/ready
// handshake. A redirect flushes the queue, marks every in-flight response as
// stale and restarts prefetch at the (word-aligned) target.
//
// Request credit: a request is only issued while count + inflight < DEPTH, so
// every response, kept or discarded, always has a queue slot reserved for it.
//
// Build option:
//   PREFETCH_BYPASS_EN  when defined, a response arriving while the queue is
//                       empty and nothing is pending discard is presented to
//                       fetch in the same cycle (and not queued if consumed).
//                       When undefined, every instruction passes through the
//                       queue and the fetch outputs come from registered state.
//
// Parameters:
//   DEPTH     queue entries and maximum in-flight requests (power of two, >= 2)
//   XLEN      PC/address width; must equal pipeline_pkg::FETCH_XLEN
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-low reset
//   mem_req_valid  out  fetch request valid
//   mem_req_ready  in   memory accepts the request
//   mem_req_addr   out  request address, bits [1:0] always zero
//   mem_rsp_valid  in   in-order response valid, never backpressured
//   mem_rsp_data   in   returned instruction
//   redirect       in   single-cycle flush/restart pulse from decode
//   redirect_pc    in   restart target, bits [1:0] ignored
//   InstrValidF    out  head instruction valid
//   InstrReadyF    in   fetch consumes the head
//   InstrF         out  head instruction, NOP when not valid
//   PCF            out  head PC, zero when not valid
// -----------------------------------------------------------------------------
module instr_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            InstrValidF,
  input  logic            InstrReadyF,
  output logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] req_pc;    // next address to request
  logic [XLEN-1:0] rsp_pc;    // PC of the next response that will be kept
  logic [CW-1:0]   count;     // queue occupancy
  logic [CW-1:0]   inflight;  // accepted requests not yet answered
  logic [CW-1:0]   drop;      // in-flight responses still to be discarded

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_keep;
  logic            bypass;
  logic            bypass_take;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // ---------------------------------------------------------------------------
  // Request issue
  // ---------------------------------------------------------------------------
  assign credit_used   = {1'b0, count} + {1'b0, inflight};
  // Gated by rst directly so no request is offered while reset is held.
  assign mem_req_valid = rst && !redirect && (credit_used < CREDIT_MAX);
  assign mem_req_addr  = req_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // ---------------------------------------------------------------------------
  // Response acceptance and optional same-cycle bypass
  // ---------------------------------------------------------------------------
  // A response in the redirect cycle belongs to the old stream.
  assign rsp_keep = mem_rsp_valid && (drop == '0) && !redirect;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = rsp_keep && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass && InstrReadyF;
  assign push        = rsp_keep && !bypass_take;
  assign pop         = InstrReadyF && !redirect && (count != '0);
  assign push_entry  = '{pc: rsp_pc, instr: mem_rsp_data};

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  // ---------------------------------------------------------------------------
  // Fetch-side outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the conditional updates, so no
  // path through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    InstrValidF = 1'b0;
    InstrF      = NOP_INSTR;
    PCF         = '0;
    if (!redirect && (count != '0)) begin
      InstrValidF = 1'b1;
      InstrF      = head.instr;
      PCF         = head.pc;
    end else if (bypass) begin
      InstrValidF = 1'b1;
      InstrF      = mem_rsp_data;
      PCF         = rsp_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit, discard and PC tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc   <= RESET_PC & ALIGN_MASK;
      rsp_pc   <= RESET_PC & ALIGN_MASK;
      inflight <= '0;
      drop     <= '0;
    end else begin
      // req_fire is already low in a redirect cycle.
      inflight <= inflight + CW'(req_fire) - CW'(mem_rsp_valid);

      if (redirect) begin
        req_pc <= redirect_pc & ALIGN_MASK;
        rsp_pc <= redirect_pc & ALIGN_MASK;
        // Every request still in flight now belongs to a dead stream. Pending
        // discards are already part of inflight, so the fresh discard count is
        // inflight less the response consumed this cycle; this keeps
        // back-to-back redirects from counting the same response twice.
        drop   <= inflight - CW'(mem_rsp_valid);
      end else begin
        if (req_fire) req_pc <= req_pc + PC_STEP;
        if (mem_rsp_valid) begin
          if (drop != '0) drop   <= drop - CNT_ONE;
          else            rsp_pc <= rsp_pc + PC_STEP;
        end
      end
    end
  end

endmodule : instr_prefetch_queue

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Directed bench for instr_prefetch_queue (DEPTH=4, XLEN=64, RESET_PC=0).
// A small in-order memory model with a selectable fixed latency answers every
// accepted request; each returned instruction is a known function of its
// address. Expected PCs and cycle positions are hand-derived; the offset L
// selects the same-cycle (bypass build) or next-cycle presentation.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
`ifdef PREFETCH_BYPASS_EN
  localparam int L = 0;
`else
  localparam int L = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b1;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid = 1'b0;
  logic [31:0]     mem_rsp_data  = '0;
  logic            redirect      = 1'b0;
  logic [XLEN-1:0] redirect_pc   = '0;
  logic            InstrValidF;
  logic            InstrReadyF   = 1'b1;
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .XLEN     (XLEN),
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .InstrValidF   (InstrValidF),
    .InstrReadyF   (InstrReadyF),
    .InstrF        (InstrF),
    .PCF           (PCF)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic            v;
    logic [XLEN-1:0] a;
  } slot_t;

  slot_t           pipe [8];
  int              lat = 2;
  logic            fire;
  logic [XLEN-1:0] fire_addr;
  int              fires;

  function automatic logic [31:0] instr_of(input logic [XLEN-1:0] pc);
    return pc[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request handshake, cross the edge, then advance the
  // memory model so the response for a request accepted at edge E is valid in
  // the cycle following edge E+lat-1.
  task automatic step();
    #1;
    fire      = mem_req_valid && mem_req_ready;
    fire_addr = mem_req_addr;
    @(posedge clk);
    #1;
    for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0].v     = fire;
    pipe[0].a     = fire_addr;
    mem_rsp_valid = pipe[lat-1].v;
    mem_rsp_data  = pipe[lat-1].v ? instr_of(pipe[lat-1].a) : 32'h0;
    #1;
  endtask

  // Hold reset across one clock edge; the memory model forgets pre-reset
  // requests. Leaves the bench in cycle c0 of the new stream.
  task automatic do_reset(input string tag);
    rst           = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    for (int i = 0; i < 8; i++) begin
      pipe[i].v = 1'b0;
      pipe[i].a = '0;
    end
    #1;
    check({tag, "_rst_req_valid"}, mem_req_valid, 1'b0);
    check({tag, "_rst_req_addr"},  mem_req_addr,  64'h0);
    check({tag, "_rst_valid"},     InstrValidF,   1'b0);
    check({tag, "_rst_instr"},     InstrF,        NOP_INSTR);
    check({tag, "_rst_pcf"},       PCF,           64'h0);
    check({tag, "_rst_count"},     dut.count,     0);
    check({tag, "_rst_inflight"},  dut.inflight,  0);
    check({tag, "_rst_drop"},      dut.drop,      0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_c0_req_valid"}, mem_req_valid, 1'b1);
    check({tag, "_c0_req_addr"},  mem_req_addr,  64'h0);
  endtask

  initial begin
    #1;
    // ---------------- streaming, latency 2, fetch always ready -------------
    lat = 2;
    InstrReadyF = 1'b1;
    do_reset("t1");
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("t1_req_valid_c%0d", c), mem_req_valid, 1'b1);
      check($sformatf("t1_req_addr_c%0d", c),  mem_req_addr,  64'(4 * c));
      if (c >= 2 + L) begin
        check($sformatf("t1_valid_c%0d", c), InstrValidF, 1'b1);
        check($sformatf("t1_pcf_c%0d", c),   PCF,         64'(4 * (c - 2 - L)));
        check($sformatf("t1_instr_c%0d", c), InstrF,      instr_of(64'(4 * (c - 2 - L))));
      end else begin
        check($sformatf("t1_valid_c%0d", c), InstrValidF, 1'b0);
        check($sformatf("t1_instr_c%0d", c), InstrF,      NOP_INSTR);
        check($sformatf("t1_pcf_c%0d", c),   PCF,         64'h0);
      end
      step();
    end

    // ---------------- reset pulsed mid-stream ------------------------------
    do_reset("t5");

    // ---------------- fetch stalled: credit limit, then drain --------------
    InstrReadyF = 1'b0;
    fires = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("t2_req_valid_c%0d", c), mem_req_valid, (c < 4));
      if (mem_req_valid && mem_req_ready) fires++;
      if (c >= 2 + L) begin
        check($sformatf("t2_valid_c%0d", c), InstrValidF, 1'b1);
        check($sformatf("t2_pcf_c%0d", c),   PCF,         64'h0);
      end else begin
        check($sformatf("t2_valid_c%0d", c), InstrValidF, 1'b0);
      end
      step();
    end
    #1;
    check("t2_fires", fires, 4);
    check("t2_count_full", dut.count, 4);
    check("t2_inflight", dut.inflight, 0);
    InstrReadyF = 1'b1;
    for (int c = 10; c < 15; c++) begin
      #1;
      check($sformatf("t2_drain_valid_c%0d", c), InstrValidF, 1'b1);
      check($sformatf("t2_drain_pcf_c%0d", c),   PCF,         64'(4 * (c - 10)));
      check($sformatf("t2_drain_instr_c%0d", c), InstrF,      instr_of(64'(4 * (c - 10))));
      step();
    end

    // ---------------- redirect with three requests in flight ---------------
    lat = 4;
    do_reset("t3");
    for (int c = 0; c < 3; c++) step();
    #1;
    check("t3_inflight_before", dut.inflight, 3);
    redirect    = 1'b1;
    redirect_pc = 64'h1002;
    #1;
    check("t3_redir_req_valid", mem_req_valid, 1'b0);
    check("t3_redir_valid",     InstrValidF,   1'b0);
    step();
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int c = 4; c <= 9 + L; c++) begin
      #1;
      if (c == 4) begin
        check("t3_drop", dut.drop, 3);
        check("t3_req_valid", mem_req_valid, 1'b1);
        check("t3_req_addr", mem_req_addr, 64'h1000);
      end
      if (c < 8 + L) begin
        check($sformatf("t3_valid_c%0d", c), InstrValidF, 1'b0);
        check($sformatf("t3_pcf_c%0d", c),   PCF,         64'h0);
      end else begin
        check($sformatf("t3_valid_c%0d", c), InstrValidF, 1'b1);
        check($sformatf("t3_pcf_c%0d", c),   PCF,         64'h1000 + 64'(4 * (c - 8 - L)));
        check($sformatf("t3_instr_c%0d", c), InstrF,      instr_of(64'h1000 + 64'(4 * (c - 8 - L))));
      end
      step();
    end

    // ---------------- redirect coinciding with a response ------------------
    lat = 3;
    do_reset("t4");
    for (int c = 0; c < 3; c++) step();
    #1;
    check("t4_inflight_before", dut.inflight, 3);
    redirect    = 1'b1;
    redirect_pc = 64'h2000;
    #1;
    check("t4_redir_valid", InstrValidF, 1'b0);
    check("t4_redir_pcf",   PCF,         64'h0);
    step();
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int c = 4; c <= 8 + L; c++) begin
      #1;
      if (c == 4) begin
        check("t4_drop", dut.drop, 2);
        check("t4_inflight_after", dut.inflight, 2);
        check("t4_req_addr", mem_req_addr, 64'h2000);
      end
      if (c < 7 + L) begin
        check($sformatf("t4_valid_c%0d", c), InstrValidF, 1'b0);
        check($sformatf("t4_pcf_c%0d", c),   PCF,         64'h0);
      end else begin
        check($sformatf("t4_valid_c%0d", c), InstrValidF, 1'b1);
        check($sformatf("t4_pcf_c%0d", c),   PCF,         64'h2000 + 64'(4 * (c - 7 - L)));
      end
      step();
    end

    // ---------------- request address wraps at the top of memory -----------
    lat = 2;
    do_reset("t7");
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    check("t7_redir_req_valid", mem_req_valid, 1'b0);
    step();
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
    check("t7_req_addr_top", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_req_valid_top", mem_req_valid, 1'b1);
    step();
    for (int c = 2; c <= 4 + L; c++) begin
      #1;
      if (c == 2) check("t7_req_addr_wrap", mem_req_addr, 64'h0);
      if (c < 3 + L) begin
        check($sformatf("t7_valid_c%0d", c), InstrValidF, 1'b0);
      end else begin
        check($sformatf("t7_valid_c%0d", c), InstrValidF, 1'b1);
        check($sformatf("t7_pcf_c%0d", c),   PCF,
              64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * (c - 3 - L)));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_prefetch_queue
